l2_fence_ctrl: RTL

- Sequences L2 fences from the moment the input decoder accepts one until completion.
- Release fences drain the write buffer; all fences then wait for outstanding MSHRs to retire.
- Acquire fences additionally sweep every L2 set/way for self-invalidation, one entry per decoder "ongoing fence" slot.
- Drives the ongoing_fence and drain_in_progress state the decoder uses for arbitration, and signals completion to the fence interface.

---
 rtl/l2_fence_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/l2_fence_ctrl.sv
// l2_fence_ctrl
// Sequences an L2 fence from decoder acceptance to completion.
//   Release fences first drain the write buffer. Every fence with a set
//   acq or rel bit then waits until all MSHRs are free. Acquire fences
//   then sweep every L2 set/way for self-invalidation, one entry per
//   granted ongoing-fence slot. A fence with neither bit set completes
//   immediately.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fence_start        one-cycle pulse, decoder accepted a fence
//   fence_acq/rel      fence type bits, sampled with fence_start
//   mshr_cnt           free MSHR count (N_MSHR when idle)
//   drain_done         write buffer empty acknowledge
//   sweep_grant        decoder granted an ongoing-fence slot
//   sweep_hold         datapath cannot take a sweep step this cycle
//   ongoing_fence      fence in progress (any state but IDLE)
//   drain_in_progress  write-buffer drain active
//   drain_req          pulse on the first drain cycle
//   sweep_valid        sweep_set/sweep_way hold a valid index
//   sweep_set/way      current sweep index
//   fence_done         one-cycle completion pulse
module l2_fence_ctrl #(
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8,
  parameter int N_MSHR  = 4,
  parameter int MSHR_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fence_start,
  input  logic                       fence_acq,
  input  logic                       fence_rel,
  input  logic [MSHR_W-1:0]          mshr_cnt,
  input  logic                       drain_done,
  input  logic                       sweep_grant,
  input  logic                       sweep_hold,
  output logic                       ongoing_fence,
  output logic                       drain_in_progress,
  output logic                       drain_req,
  output logic                       sweep_valid,
  output logic [$clog2(L2_SETS)-1:0] sweep_set,
  output logic [$clog2(L2_WAYS)-1:0] sweep_way,
  output logic                       fence_done
);

  localparam int SET_W = $clog2(L2_SETS);
  localparam int WAY_W = $clog2(L2_WAYS);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(L2_SETS - 1);
  localparam logic [WAY_W-1:0]  WAY_LAST  = WAY_W'(L2_WAYS - 1);
  localparam logic [MSHR_W-1:0] MSHR_IDLE = MSHR_W'(N_MSHR);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_WAIT_MSHR = 3'd2,
    ST_SWEEP     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             acq_r;
  logic             rel_r;
  logic [SET_W-1:0] set_r;
  logic [WAY_W-1:0] way_r;
  logic             step_s;
  logic             last_s;

  logic ongoing_s;
  logic drain_ip_s;
  logic drain_req_s;
  logic sweep_valid_s;
  logic fence_done_s;

  logic ongoing_r;
  logic drain_ip_r;
  logic drain_req_r;
  logic sweep_valid_r;
  logic fence_done_r;

  // A held grant is a no-op; last_s marks the final set/way of the sweep.
  assign step_s = sweep_grant & ~sweep_hold;
  assign last_s = (set_r == SET_LAST) && (way_r == WAY_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fence_start) begin
          if (fence_rel) begin
            next_state_s = ST_DRAIN;
          end else if (fence_acq) begin
            next_state_s = ST_WAIT_MSHR;
          end else begin
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          next_state_s = ST_WAIT_MSHR;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_WAIT_MSHR: begin
        if (mshr_cnt == MSHR_IDLE) begin
          if (acq_r) begin
            next_state_s = ST_SWEEP;
          end else begin
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_WAIT_MSHR;
        end
      end
      ST_SWEEP: begin
        if (step_s && last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SWEEP;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs are Moore
  // outputs of the state they accompany. drain_req fires on DRAIN entry.
  always_comb begin
    ongoing_s     = (next_state_s != ST_IDLE);
    drain_ip_s    = (next_state_s == ST_DRAIN);
    sweep_valid_s = (next_state_s == ST_SWEEP);
    fence_done_s  = (next_state_s == ST_DONE);
    drain_req_s   = (state_r == ST_IDLE) && (next_state_s == ST_DRAIN);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ongoing_r     <= 1'b0;
      drain_ip_r    <= 1'b0;
      drain_req_r   <= 1'b0;
      sweep_valid_r <= 1'b0;
      fence_done_r  <= 1'b0;
    end else begin
      ongoing_r     <= ongoing_s;
      drain_ip_r    <= drain_ip_s;
      drain_req_r   <= drain_req_s;
      sweep_valid_r <= sweep_valid_s;
      fence_done_r  <= fence_done_s;
    end
  end

  // Fence type flags: latched only when a fence is accepted in IDLE,
  // cleared as the fence retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      acq_r <= 1'b0;
      rel_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && fence_start) begin
      acq_r <= fence_acq;
      rel_r <= fence_rel;
    end else if (state_r == ST_DONE) begin
      acq_r <= 1'b0;
      rel_r <= 1'b0;
    end else begin
      acq_r <= acq_r;
      rel_r <= rel_r;
    end
  end

  // Sweep index counters: way is the fast index; the final step returns
  // both to zero so the next acquire starts at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      set_r <= '0;
      way_r <= '0;
    end else if ((state_r == ST_SWEEP) && step_s) begin
      if (last_s) begin
        set_r <= '0;
        way_r <= '0;
      end else if (way_r == WAY_LAST) begin
        set_r <= set_r + SET_W'(1);
        way_r <= '0;
      end else begin
        set_r <= set_r;
        way_r <= way_r + WAY_W'(1);
      end
    end else begin
      set_r <= set_r;
      way_r <= way_r;
    end
  end

  assign ongoing_fence     = ongoing_r;
  assign drain_in_progress = drain_ip_r;
  assign drain_req         = drain_req_r;
  assign sweep_valid       = sweep_valid_r;
  assign fence_done        = fence_done_r;
  assign sweep_set         = set_r;
  assign sweep_way         = way_r;

endmodule
